// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between NREQ requesters. A round-robin
//   arbiter picks at most one request per cycle, steers its operands to the
//   ALU, and registers the ALU result into a single-entry response slot
//   tagged with the requester index.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b/req_op     packed payloads, requester i at [i*W +: W]
//   alu_a/alu_b/alu_op     to the shared ALU (zero when nothing is granted)
//   alu_result/alu_flags   from the shared ALU, flags are {N,Z,C,V}
//   rsp_valid/rsp_ready    response slot handshake
//   rsp_id/rsp_result/rsp_flags  registered response contents
//
// State table
//   state  | meaning
//   S_IDLE | response slot empty
//   S_FULL | response slot holds a result (rsp_valid=1)
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int OPW   = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OPW-1:0]        alu_op,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags
);

  typedef enum logic {S_IDLE, S_FULL} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] rr_next;
  logic [IDW:0]   scan_idx;
  logic [IDW:0]   ptr_inc;
  logic           found;
  logic           can_issue;
  logic           grant;

  assign can_issue = (state_q == S_IDLE) || rsp_ready;
  // Reset suppresses the grant so a request seen during reset is not consumed.
  assign grant     = can_issue && found && !reset;

  // Round-robin scan starting at rr_ptr; one extra bit holds the sum before wrap.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      scan_idx = {1'b0, rr_ptr} + (IDW+1)'(off);
      if (scan_idx >= (IDW+1)'(NREQ))
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      if (!found && req_valid[scan_idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, win} + (IDW+1)'(1);
    if (ptr_inc >= (IDW+1)'(NREQ))
      ptr_inc = '0;
    rr_next = ptr_inc[IDW-1:0];
  end

  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && (win == IDW'(i))) begin
        req_ready[i] = 1'b1;
        alu_a        = req_a[i*WIDTH +: WIDTH];
        alu_b        = req_b[i*WIDTH +: WIDTH];
        alu_op       = req_op[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (grant) state_d = S_FULL;
      S_FULL: begin
        if (grant)          state_d = S_FULL;
        else if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_ptr     <= rr_next;
        rsp_id     <= win;
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
      end
    end
  end

  assign rsp_valid = (state_q == S_FULL);

endmodule
